// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter that funnels per-drive block read/write requests onto one SD host port.
// Each channel queues sticky read/write requests; one request is granted at a time and tracked through REQ and XFER.
module sd_block_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int LBA_W   = 32,
  parameter int TIMEOUT = 2**20,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       ch_rd,
  input  logic [NUM_CH-1:0]       ch_wr,
  input  logic [NUM_CH*LBA_W-1:0] ch_lba,
  input  logic [NUM_CH-1:0]       ch_ro,
  output logic [NUM_CH-1:0]       ch_wait,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_err,
  output logic                    sd_rd,
  output logic                    sd_wr,
  output logic [LBA_W-1:0]        sd_lba,
  output logic [SEL_W-1:0]        sd_ch,
  input  logic                    sd_ack,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("sd_block_arbiter: NUM_CH must be in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] pend_rd;
  logic [NUM_CH-1:0] pend_wr;
  logic [SEL_W-1:0]  last_grant;
  logic              old_ack;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [NUM_CH-1:0] any_pend;
  logic [NUM_CH-1:0] sel_mask;
  logic [NUM_CH-1:0] svc_clr;
  logic [NUM_CH-1:0] tmo_err;
  logic [NUM_CH-1:0] rd_clr;
  logic [NUM_CH-1:0] wr_clr;
  logic              ack_rise;
  logic              ack_fall;
  logic              tmo_hit;
  logic              grant_found;
  logic [SEL_W-1:0]  grant_idx;
  logic [LBA_W-1:0]  grant_lba;

  assign any_pend = pend_rd | pend_wr;
  assign sel_mask = NUM_CH'(1) << sd_ch;
  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // The granted channel stays counted as waiting until its transfer finishes.
  assign ch_wait   = any_pend | ((state != IDLE) ? sel_mask : '0);
  assign dbg_state = state;

  // Round-robin search starting just after the channel that last completed.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!grant_found && any_pend[idx[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[SEL_W-1:0];
      end
    end
  end

  assign grant_lba = ch_lba[int'(grant_idx)*LBA_W +: LBA_W];

  // The serviced pending bit is retired on ack rise or on timeout; an ack wins a tie.
  always_comb begin
    svc_clr = '0;
    tmo_err = '0;
    if (state == REQ && (ack_rise || tmo_hit)) svc_clr = sel_mask;
    if (state == REQ && !ack_rise && tmo_hit) tmo_err = sel_mask;
  end

  assign rd_clr = sd_rd ? svc_clr : '0;
  assign wr_clr = sd_wr ? svc_clr : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_rd    <= '0;
      pend_wr    <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
      old_ack    <= 1'b0;
      tmo_cnt    <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_lba     <= '0;
      sd_ch      <= '0;
      ch_done    <= '0;
      ch_err     <= '0;
    end else begin
      old_ack <= sd_ack;
      ch_done <= '0;
      ch_err  <= '0;
      if (abort) begin
        state   <= IDLE;
        pend_rd <= '0;
        pend_wr <= '0;
        tmo_cnt <= '0;
        sd_rd   <= 1'b0;
        sd_wr   <= 1'b0;
        sd_lba  <= '0;
        sd_ch   <= '0;
      end else begin
        // New pulses win over a same-cycle clear so a re-request is never lost.
        pend_rd <= (pend_rd & ~rd_clr) | ch_rd;
        pend_wr <= (pend_wr & ~wr_clr) | (ch_wr & ~ch_ro);
        ch_err  <= (ch_wr & ch_ro) | tmo_err;
        case (state)
          IDLE: begin
            if (grant_found) begin
              sd_ch   <= grant_idx;
              sd_lba  <= grant_lba;
              sd_rd   <= pend_rd[grant_idx];
              sd_wr   <= ~pend_rd[grant_idx];
              tmo_cnt <= '0;
              state   <= REQ;
            end
          end
          REQ: begin
            if (ack_rise) begin
              sd_rd <= 1'b0;
              sd_wr <= 1'b0;
              state <= XFER;
            end else if (tmo_hit) begin
              sd_rd <= 1'b0;
              sd_wr <= 1'b0;
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          XFER: begin
            if (ack_fall) begin
              ch_done    <= sel_mask;
              last_grant <= sd_ch;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed and randomized checks of sd_block_arbiter against a round-robin reference model.
// The bench plays the SD host: it answers each grant with a randomly delayed ack pulse.
module tb_sd_block_arbiter;
  localparam int NUM_CH  = 3;
  localparam int LBA_W   = 32;
  localparam int TIMEOUT = 16;
  localparam int SEL_W   = 2;
  localparam int W       = SEL_W + 1 + LBA_W;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    abort;
  logic [NUM_CH-1:0]       ch_rd;
  logic [NUM_CH-1:0]       ch_wr;
  logic [NUM_CH*LBA_W-1:0] ch_lba;
  logic [NUM_CH-1:0]       ch_ro;
  logic [NUM_CH-1:0]       ch_wait;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_err;
  logic                    sd_rd;
  logic                    sd_wr;
  logic [LBA_W-1:0]        sd_lba;
  logic [SEL_W-1:0]        sd_ch;
  logic                    sd_ack;
  logic [1:0]              dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  sd_block_arbiter #(.NUM_CH(NUM_CH), .LBA_W(LBA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_lba(ch_lba), .ch_ro(ch_ro),
    .ch_wait(ch_wait), .ch_done(ch_done), .ch_err(ch_err),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ch(sd_ch),
    .sd_ack(sd_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int c);
    return NUM_CH'(1) << c;
  endfunction

  task automatic do_reset();
    ch_rd = '0; ch_wr = '0; ch_ro = '0; abort = 1'b0; sd_ack = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    check("rst_sd_req", {sd_rd, sd_wr}, 0);
    check("rst_sd_sel", {sd_ch, sd_lba}, 0);
    check("rst_ch_out", {ch_wait, ch_done, ch_err}, 0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // SD host driver: wait for a grant, ack it after a random delay, check done.
  task automatic serve(output logic [W-1:0] got, output bit ok);
    int n;
    logic [SEL_W-1:0] c;
    logic [LBA_W-1:0] l;
    logic             w;
    ok = 1'b0;
    got = '0;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 50) begin
      tick();
      n++;
    end
    if (!(sd_rd || sd_wr)) begin
      check("grant_timeout", 0, 1);
      return;
    end
    check("rd_wr_excl", sd_rd & sd_wr, 0);
    c = sd_ch; l = sd_lba; w = sd_wr;
    got = {c, w, l};
    repeat ($urandom_range(0, 8)) tick();
    check("req_held", {sd_rd, sd_wr}, {~w, w});
    check("lba_stable_req", sd_lba, l);
    sd_ack = 1'b1;
    tick();
    check("req_drop_on_ack", {sd_rd, sd_wr}, 0);
    repeat ($urandom_range(1, 6)) tick();
    check("sel_stable_xfer", {sd_ch, sd_lba}, {c, l});
    check("no_early_done", ch_done, 0);
    sd_ack = 1'b0;
    tick();
    check("done_pulse", ch_done, onehot(int'(c)));
    ok = 1'b1;
  endtask

  // Reference: round-robin from last+1, read before write, last updated on completion.
  task automatic model_order(input logic [NUM_CH-1:0] rd, input logic [NUM_CH-1:0] wr,
                             inout int last);
    logic [NUM_CH-1:0] rp;
    logic [NUM_CH-1:0] wp;
    int c;
    rp = rd; wp = wr;
    while ((rp | wp) != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (last + k) % NUM_CH;
        if (rp[c] || wp[c]) begin
          if (rp[c]) begin
            exp_q.push_back({SEL_W'(c), 1'b0, ch_lba[c*LBA_W +: LBA_W]});
            rp[c] = 1'b0;
          end else begin
            exp_q.push_back({SEL_W'(c), 1'b1, ch_lba[c*LBA_W +: LBA_W]});
            wp[c] = 1'b0;
          end
          last = c;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    bit ok;
    int cnt;
    int n;
    int last;
    logic seen;
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] ro;

    reset_n = 1'b0;
    ch_lba = '0;
    do_reset();

    // single read on ch1, fixed timing
    ch_lba[1*LBA_W +: LBA_W] = 32'h1234;
    ch_rd = 3'b010;
    tick();
    ch_rd = '0;
    check("c1_no_early_grant", {sd_rd, sd_wr}, 0);
    check("c1_wait_pending", ch_wait, 3'b010);
    tick();
    check("c2_sd_rd", {sd_rd, sd_wr}, 2'b10);
    check("c2_sd_ch", sd_ch, 1);
    check("c2_sd_lba", sd_lba, 32'h1234);
    repeat (8) tick();
    sd_ack = 1'b1;
    tick();
    check("c11_rd_drop", sd_rd, 0);
    repeat (9) tick();
    sd_ack = 1'b0;
    tick();
    check("c21_done", ch_done, 3'b010);
    check("c21_wait_clear", ch_wait, 3'b000);
    tick();
    check("c22_done_once", ch_done, 3'b000);

    // simultaneous reads after reset: order 0,1,2
    do_reset();
    for (int i = 0; i < NUM_CH; i++) ch_lba[i*LBA_W +: LBA_W] = 32'h100 + i;
    ch_rd = 3'b111;
    tick();
    ch_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      serve(got, ok);
      check("rr_order", got, {SEL_W'(i), 1'b0, 32'h100 + i});
    end
    tick();
    check("rr_wait_clear", ch_wait, 3'b000);

    // write to read-only image on ch2
    do_reset();
    ch_ro = 3'b100;
    ch_wr = 3'b100;
    tick();
    ch_wr = '0;
    ch_ro = '0;
    check("ro_err_pulse", ch_err, 3'b100);
    check("ro_wait", ch_wait, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | sd_wr | sd_rd | ch_wait[2] | ch_err[2];
    end
    check("ro_no_activity", seen, 0);

    // timeout with no ack
    do_reset();
    ch_rd = 3'b001;
    tick();
    ch_rd = '0;
    tick();
    cnt = 0; n = 0;
    while (sd_rd && n < 40) begin
      cnt++;
      tick();
      n++;
    end
    check("tmo_hold_cycles", cnt, TIMEOUT);
    check("tmo_err_pulse", ch_err, 3'b001);
    check("tmo_wait_clear", ch_wait, 3'b000);
    tick();
    check("tmo_err_once", ch_err, 3'b000);
    check("tmo_idle_no_regrant", {sd_rd, sd_wr}, 0);

    // read and write pending together on ch0
    do_reset();
    ch_lba[0 +: LBA_W] = 32'hABCD;
    ch_rd = 3'b001;
    ch_wr = 3'b001;
    tick();
    ch_rd = '0; ch_wr = '0;
    serve(got, ok);
    check("rw_read_first", got, {SEL_W'(0), 1'b0, 32'hABCD});
    check("rw_wait_across_done", ch_wait[0], 1);
    serve(got, ok);
    check("rw_write_second", got, {SEL_W'(0), 1'b1, 32'hABCD});
    check("rw_wait_final", ch_wait, 3'b000);

    // abort in XFER with ch1 pending
    do_reset();
    ch_rd = 3'b001;
    tick();
    ch_rd = '0;
    tick();
    check("ab_granted", sd_rd, 1);
    sd_ack = 1'b1;
    tick();
    ch_rd = 3'b010;
    tick();
    ch_rd = 3'b100;
    check("ab_pending_before", ch_wait, 3'b011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ch_rd = '0;
    check("ab_req_clear", {sd_rd, sd_wr}, 0);
    check("ab_outputs_clear", {ch_wait, ch_done, ch_err}, 0);
    sd_ack = 1'b0;
    tick();
    check("ab_no_done", ch_done, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | sd_rd | sd_wr | (|ch_done) | (|ch_wait);
    end
    check("ab_stays_idle", seen, 0);

    // randomized rounds against the reference model
    do_reset();
    last = NUM_CH - 1;
    for (int r = 0; r < 25; r++) begin
      rd = NUM_CH'($urandom_range(0, 7));
      wr = NUM_CH'($urandom_range(0, 7));
      ro = NUM_CH'($urandom_range(0, 7));
      if ((rd | (wr & ~ro)) == 0) rd = onehot($urandom_range(0, NUM_CH - 1));
      for (int i = 0; i < NUM_CH; i++) ch_lba[i*LBA_W +: LBA_W] = $urandom();
      ch_rd = rd; ch_wr = wr; ch_ro = ro;
      tick();
      ch_rd = '0; ch_wr = '0; ch_ro = '0;
      check("rnd_ro_err", ch_err, wr & ro);
      check("rnd_wait", ch_wait, rd | (wr & ~ro));
      model_order(rd, wr & ~ro, last);
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        serve(got, ok);
        check("rnd_grant", got, exp);
        if (!ok) begin
          exp_q.delete();
          break;
        end
      end
      tick();
      check("rnd_wait_clear", ch_wait, 0);
      if (!ok) begin
        do_reset();
        last = NUM_CH - 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
